// File: rtl/mp3_stream_feeder_if.sv
// Song-ROM read port and VS1003 SDI pins shared by the stream feeder and its surroundings.
interface mp3_stream_feeder_if #(
    parameter int unsigned ADDR_W = 16
);
    logic [ADDR_W-1:0] ROM_ADDR;
    logic [7:0]        ROM_DATA;
    logic              MP3_DREQ;
    logic              MP3_XDCS;
    logic              MP3_DCLK;
    logic              MP3_SI;

    modport master (
        output ROM_ADDR,
        output MP3_XDCS,
        output MP3_DCLK,
        output MP3_SI,
        input  ROM_DATA,
        input  MP3_DREQ
    );

    modport slave (
        input  ROM_ADDR,
        input  MP3_XDCS,
        input  MP3_DCLK,
        input  MP3_SI,
        output ROM_DATA,
        output MP3_DREQ
    );
endinterface

// File: rtl/mp3_stream_feeder.sv
// Streams song-ROM bytes into the VS1003 SDI port in DREQ-gated chunks, MSB first,
// pausing only at byte boundaries.
module mp3_stream_feeder #(
    parameter int unsigned       ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] END_ADDR = 16'hFFFF,
    parameter int unsigned       CHUNK    = 32
) (
    input  logic                 MP3_SCLK,
    input  logic                 RESET,
    input  logic                 IS_SUSPENDING,
    mp3_stream_feeder_if.master  bus,
    output logic                 SONG_DONE
);
    localparam int unsigned CntW = (CHUNK > 1) ? $clog2(CHUNK) : 1;

    typedef enum logic [2:0] {StIdle, StWait, StFetch, StLoad, StShift} state_e;

    state_e            state_q, state_d;
    logic [3:0]        k_q, k_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [7:0]        sr_q, sr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              xdcs_q, xdcs_d;
    logic              dclk_q, dclk_d;
    logic              si_q, si_d;
    logic              done_q, done_d;
    logic              last_in_chunk;
    logic              at_end;

    assign last_in_chunk = (cnt_q == CntW'(CHUNK - 1));
    assign at_end        = (addr_q == END_ADDR);

    always_ff @(posedge MP3_SCLK) begin
        if (RESET) begin
            state_q <= StIdle;
            k_q     <= '0;
            cnt_q   <= '0;
            sr_q    <= '0;
            addr_q  <= '0;
            xdcs_q  <= 1'b1;
            dclk_q  <= 1'b0;
            si_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            addr_q  <= addr_d;
            xdcs_q  <= xdcs_d;
            dclk_q  <= dclk_d;
            si_q    <= si_d;
            done_q  <= done_d;
        end
    end

    // Next values are computed for the cycle being entered, so every pin comes straight off a flop.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        addr_d  = addr_q;
        xdcs_d  = xdcs_q;
        dclk_d  = 1'b0;
        si_d    = 1'b0;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                xdcs_d  = 1'b1;
                state_d = StWait;
            end
            StWait: begin
                xdcs_d = 1'b1;
                if (!IS_SUSPENDING && bus.MP3_DREQ) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                xdcs_d  = 1'b0;
                state_d = StLoad;
            end
            StLoad: begin
                xdcs_d  = 1'b0;
                sr_d    = bus.ROM_DATA;
                si_d    = bus.ROM_DATA[7];
                k_d     = 4'd0;
                state_d = StShift;
            end
            StShift: begin
                xdcs_d = 1'b0;
                if (k_q != 4'd15) begin
                    k_d    = k_q + 4'd1;
                    dclk_d = ~k_q[0];
                    // Advance to the next bit only after the high half, so SI spans low+high.
                    if (k_q[0]) begin
                        sr_d = {sr_q[6:0], 1'b0};
                        si_d = sr_q[6];
                    end else begin
                        si_d = si_q;
                    end
                end else begin
                    done_d = at_end;
                    addr_d = at_end ? '0 : addr_q + ADDR_W'(1);
                    cnt_d  = last_in_chunk ? '0 : cnt_q + CntW'(1);
                    if (last_in_chunk || IS_SUSPENDING) begin
                        xdcs_d  = 1'b1;
                        state_d = StWait;
                    end else begin
                        state_d = StFetch;
                    end
                end
            end
            default: begin
                xdcs_d  = 1'b1;
                state_d = StIdle;
            end
        endcase
    end

    assign bus.ROM_ADDR = addr_q;
    assign bus.MP3_XDCS = xdcs_q;
    assign bus.MP3_DCLK = dclk_q;
    assign bus.MP3_SI   = si_q;
    assign SONG_DONE    = done_q;
endmodule

// File: tb/tb_mp3_stream_feeder.sv
// Bench for mp3_stream_feeder: a byte-phase model checks two instances (long song and
// 4-byte song) every cycle, plus directed literal checks.
module tb_mp3_stream_feeder;
    localparam int CHUNK = 32;
    localparam int END_A [2] = '{65535, 3};

    logic clk = 1'b0;
    logic rst;
    logic susp;
    logic dreq;
    logic done0, done1;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mp3_stream_feeder_if #(.ADDR_W(16)) if0 ();
    mp3_stream_feeder_if #(.ADDR_W(16)) if1 ();

    mp3_stream_feeder #(.ADDR_W(16), .END_ADDR(16'hFFFF), .CHUNK(CHUNK)) u_dut0 (
        .MP3_SCLK(clk), .RESET(rst), .IS_SUSPENDING(susp), .bus(if0.master), .SONG_DONE(done0)
    );
    mp3_stream_feeder #(.ADDR_W(16), .END_ADDR(16'h0003), .CHUNK(CHUNK)) u_dut1 (
        .MP3_SCLK(clk), .RESET(rst), .IS_SUSPENDING(susp), .bus(if1.master), .SONG_DONE(done1)
    );

    function automatic logic [7:0] rom_byte(input logic [15:0] a);
        logic [15:0] p;
        if (a == 16'd0) return 8'hA5;
        p = a * 16'd37;
        return p[7:0] ^ 8'h5C;
    endfunction

    assign if0.MP3_DREQ = dreq;
    assign if1.MP3_DREQ = dreq;
    always @(posedge clk) begin
        if0.ROM_DATA <= rom_byte(if0.ROM_ADDR);
        if1.ROM_DATA <= rom_byte(if1.ROM_ADDR);
    end

    logic [15:0] d_addr [2];
    logic        d_xdcs [2];
    logic        d_dclk [2];
    logic        d_si   [2];
    logic        d_done [2];
    assign d_addr[0] = if0.ROM_ADDR;  assign d_addr[1] = if1.ROM_ADDR;
    assign d_xdcs[0] = if0.MP3_XDCS;  assign d_xdcs[1] = if1.MP3_XDCS;
    assign d_dclk[0] = if0.MP3_DCLK;  assign d_dclk[1] = if1.MP3_DCLK;
    assign d_si[0]   = if0.MP3_SI;    assign d_si[1]   = if1.MP3_SI;
    assign d_done[0] = done0;         assign d_done[1] = done1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    // Model: mode 0 idle, 1 waiting for DREQ, 2 moving a byte at phase pos 0..17
    int m_mode [2];
    int m_pos  [2];
    int m_addr [2];
    int m_cnt  [2];
    bit m_cont [2];
    bit m_done [2];
    bit started = 1'b0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_mode[i] = 0; m_pos[i] = 0; m_addr[i] = 0;
                m_cnt[i]  = 0; m_cont[i] = 0; m_done[i] = 0;
            end else begin
                m_done[i] = 0;
                if (m_mode[i] == 0) begin
                    m_mode[i] = 1;
                end else if (m_mode[i] == 1) begin
                    if (!susp && dreq) begin
                        m_mode[i] = 2; m_pos[i] = 0; m_cont[i] = 0;
                    end
                end else if (m_pos[i] < 17) begin
                    m_pos[i]++;
                end else begin
                    m_done[i] = (m_addr[i] == END_A[i]);
                    m_addr[i] = m_done[i] ? 0 : m_addr[i] + 1;
                    m_cnt[i]  = (m_cnt[i] + 1) % CHUNK;
                    if (m_cnt[i] == 0 || susp) m_mode[i] = 1;
                    else begin m_pos[i] = 0; m_cont[i] = 1; end
                end
            end
        end
        started = 1'b1;
    end

    always @(negedge clk) begin : compare
        int k;
        logic [7:0] b;
        logic e_xdcs, e_dclk, e_si;
        if (started) begin
            for (int i = 0; i < 2; i++) begin
                e_xdcs = 1'b1; e_dclk = 1'b0; e_si = 1'b0;
                if (m_mode[i] == 2) begin
                    if (m_pos[i] == 0) e_xdcs = !m_cont[i];
                    else if (m_pos[i] == 1) e_xdcs = 1'b0;
                    else begin
                        k = m_pos[i] - 2;
                        b = rom_byte(16'(m_addr[i]));
                        e_xdcs = 1'b0;
                        e_dclk = (k % 2) == 1;
                        e_si   = b[7 - k / 2];
                    end
                end
                chk($sformatf("d%0d_addr", i), 32'(d_addr[i]), 32'(m_addr[i]));
                chk($sformatf("d%0d_xdcs", i), 32'(d_xdcs[i]), 32'(e_xdcs));
                chk($sformatf("d%0d_dclk", i), 32'(d_dclk[i]), 32'(e_dclk));
                chk($sformatf("d%0d_si", i),   32'(d_si[i]),   32'(e_si));
                chk($sformatf("d%0d_done", i), 32'(d_done[i]), 32'(m_done[i]));
            end
        end
    end

    // First-byte-to-SONG_DONE latency on the 4-byte song instance
    int  cyc = 0;
    int  t_fall1 = -1;
    int  t_done1 = -1;
    logic prev_xdcs1 = 1'b1;
    always @(negedge clk) begin
        cyc++;
        if (started) begin
            if (t_fall1 < 0 && prev_xdcs1 === 1'b1 && if1.MP3_XDCS === 1'b0) t_fall1 = cyc;
            if (t_done1 < 0 && done1 === 1'b1) begin
                t_done1 = cyc;
                chk("d1_done_wrap_addr", 32'(if1.ROM_ADDR), 32'd0);
            end
            prev_xdcs1 = if1.MP3_XDCS;
        end
    end

    initial begin : stim
        logic [7:0] bits;
        int nb, run, guard, ndclk;
        logic seen_low;

        rst = 1'b1; susp = 1'b0; dreq = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_xdcs", 32'(if0.MP3_XDCS), 32'd1);
        chk("rst_addr", 32'(if0.ROM_ADDR), 32'd0);
        rst = 1'b0;

        // Starved decoder: nothing moves for 100 cycles
        repeat (100) @(negedge clk);
        chk("starved_addr", 32'(if0.ROM_ADDR), 32'd0);
        chk("starved_xdcs", 32'(if0.MP3_XDCS), 32'd1);
        dreq = 1'b1;
        @(negedge clk);
        chk("fetch_xdcs_high", 32'(if0.MP3_XDCS), 32'd1);
        @(negedge clk);
        chk("load_xdcs_low", 32'(if0.MP3_XDCS), 32'd0);
        run = 1;

        bits = 8'h00; nb = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (if0.MP3_XDCS == 1'b0) run++;
            if (if0.MP3_DCLK) begin
                bits = {bits[6:0], if0.MP3_SI};
                nb++;
            end
        end
        chk("byte0_bits", 32'(bits), 32'hA5);
        chk("byte0_nbits", 32'(nb), 32'd8);
        @(negedge clk);
        if (if0.MP3_XDCS == 1'b0) run++;
        chk("byte1_addr_after_18", 32'(if0.ROM_ADDR), 32'd1);

        // Measure the low stretch of XDCS over the rest of the first chunk
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
            if (if0.MP3_XDCS == 1'b0) run++;
        end while (if0.MP3_XDCS == 1'b0 && guard < 2000);
        chk("chunk_cycles_fetch_plus_low", 32'(run + 1), 32'd576);
        chk("chunk_end_addr", 32'(if0.ROM_ADDR), 32'd32);

        // Let bytes 32.. start, then drop DREQ; the second chunk still completes
        repeat (10) @(negedge clk);
        dreq = 1'b0;
        guard = 0;
        while (if0.MP3_XDCS != 1'b1 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        chk("chunk2_end_addr", 32'(if0.ROM_ADDR), 32'd64);
        chk("song_done_latency", 32'(t_done1 - t_fall1), 32'd71);

        // Pause in the middle of byte 5
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0; dreq = 1'b1;
        repeat (100) @(negedge clk);
        susp = 1'b1;
        repeat (20) @(negedge clk);
        chk("pause_xdcs", 32'(if0.MP3_XDCS), 32'd1);
        chk("pause_addr", 32'(if0.ROM_ADDR), 32'd6);
        ndclk = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (if0.MP3_DCLK) ndclk++;
        end
        chk("pause_no_dclk", 32'(ndclk), 32'd0);

        susp = 1'b0;
        seen_low = 1'b0; ndclk = 0; guard = 0;
        do begin
            @(negedge clk);
            guard++;
            if (if0.MP3_XDCS == 1'b0) seen_low = 1'b1;
            if (if0.MP3_DCLK) ndclk++;
        end while (!(seen_low && if0.MP3_XDCS == 1'b1) && guard < 2000);
        dreq = 1'b0;
        chk("resume_bits_rest_of_chunk", 32'(ndclk), 32'd208);
        chk("resume_end_addr", 32'(if0.ROM_ADDR), 32'd32);

        // Reset mid-byte at SHIFT k=7
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0; dreq = 1'b1;
        repeat (11) @(negedge clk);
        chk("k7_dclk_high", 32'(if0.MP3_DCLK), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midbyte_rst_xdcs", 32'(if0.MP3_XDCS), 32'd1);
        chk("midbyte_rst_dclk", 32'(if0.MP3_DCLK), 32'd0);
        chk("midbyte_rst_si", 32'(if0.MP3_SI), 32'd0);
        chk("midbyte_rst_addr", 32'(if0.ROM_ADDR), 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("restart_addr", 32'(if0.ROM_ADDR), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
